// File: rtl/song_writer_pkg.sv
// Shared definitions for the song RAM entry format, common with song_reader.
package song_writer_pkg;

    localparam int SONG_WIDTH     = 7;
    localparam int NOTE_WIDTH     = 6;
    localparam int DURATION_WIDTH = 6;
    localparam int METADATA_WIDTH = 3;
    localparam int SLOT_WIDTH     = 2;
    localparam int ADDR_WIDTH     = SLOT_WIDTH + SONG_WIDTH;
    localparam int ENTRY_WIDTH    = 16;

    // Entry field offsets
    localparam int TYPE_BIT = 15;
    localparam int NOTE_LSB = 9;
    localparam int DUR_LSB  = 3;

    localparam logic TYPE_NOTE    = 1'b0;
    localparam logic TYPE_ADVANCE = 1'b1;
    localparam logic [METADATA_WIDTH-1:0] METADATA = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_HELD,
        ST_WR_REST,
        ST_WR_NOTE,
        ST_WR_ADV,
        ST_FULL
    } state_t;

    function automatic logic [ENTRY_WIDTH-1:0] make_entry(
        input logic                      typ,
        input logic [NOTE_WIDTH-1:0]     note,
        input logic [DURATION_WIDTH-1:0] dur
    );
        logic [ENTRY_WIDTH-1:0] e;
        e = '0;
        e[TYPE_BIT]                   = typ;
        e[NOTE_LSB +: NOTE_WIDTH]     = note;
        e[DUR_LSB +: DURATION_WIDTH]  = dur;
        e[METADATA_WIDTH-1:0]         = METADATA;
        return e;
    endfunction

endpackage

// File: rtl/song_writer_if.sv
// Song RAM write port.
interface song_writer_if;
    import song_writer_pkg::*;

    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [ENTRY_WIDTH-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/song_writer_beat_counter.sv
// Saturating beat counter: synchronous clear wins over tick.
module song_writer_beat_counter
    import song_writer_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      tick,
    output logic [DURATION_WIDTH-1:0] count
);

    localparam logic [DURATION_WIDTH-1:0] COUNT_MAX = '1;

    // Count ticks, holding at the maximum value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && (count != COUNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/song_writer.sv
// Live recorder: turns key presses timed against beat ticks into song entries.
//
// state      | meaning
// IDLE       | no session; waiting for a record rising edge
// ARMED      | counting the gap before the next key press
// HELD       | counting how long the key is held
// WR_REST    | writing an advance entry for the gap
// WR_NOTE    | writing the note entry
// WR_ADV     | writing the advance entry that follows a note
// FULL       | song slot full; waiting for record to drop
module song_writer
    import song_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  record,
    input  logic [SLOT_WIDTH-1:0] song,
    input  logic                  beat_tick,
    input  logic                  key_pressed,
    input  logic [NOTE_WIDTH-1:0] key_note,
    song_writer_if.master         ram,
    output logic                  recording,
    output logic                  full,
    output logic                  record_done,
    output logic [SONG_WIDTH:0]   entry_count
);

    state_t                    state, next_state;
    logic                      record_q, key_q;
    logic [NOTE_WIDTH-1:0]     note_q, note_latched;
    logic [SLOT_WIDTH-1:0]     song_latched;
    logic [SONG_WIDTH-1:0]     entry_idx;
    logic [DURATION_WIDTH-1:0] beat_count, dur;
    logic                      write, latch_song, latch_note, session_end;
    logic                      counting, count_clear;
    logic [ENTRY_WIDTH-1:0]    data;

    assign counting    = (state == ST_ARMED) || (state == ST_HELD);
    assign count_clear = (next_state != state) &&
                         ((next_state == ST_ARMED) || (next_state == ST_HELD));
    assign dur         = (beat_count == '0) ? {{(DURATION_WIDTH-1){1'b0}}, 1'b1} : beat_count;

    song_writer_beat_counter u_beat_counter (
        .clk   (clk),
        .reset (reset),
        .clear (count_clear),
        .tick  (beat_tick && counting),
        .count (beat_count)
    );

    // Next state, write strobe and entry encoding; a write at the last index forces FULL.
    always_comb begin
        next_state  = state;
        write       = 1'b0;
        data        = '0;
        latch_song  = 1'b0;
        latch_note  = 1'b0;
        session_end = 1'b0;
        case (state)
            ST_IDLE: begin
                if (record && !record_q) begin
                    next_state = ST_ARMED;
                    latch_song = 1'b1;
                end
            end
            ST_ARMED: begin
                if (!record) begin
                    next_state  = ST_IDLE;
                    session_end = 1'b1;
                end else if (key_q) begin
                    latch_note = 1'b1;
                    // A tick in this same cycle still belongs to the gap.
                    next_state = ((beat_count != '0) || beat_tick) ? ST_WR_REST : ST_HELD;
                end
            end
            ST_HELD: begin
                if (!key_q || !record) begin
                    next_state = ST_WR_NOTE;
                end
            end
            ST_WR_REST: begin
                write      = 1'b1;
                data       = make_entry(TYPE_ADVANCE, '0, dur);
                next_state = ST_HELD;
            end
            ST_WR_NOTE: begin
                write      = 1'b1;
                data       = make_entry(TYPE_NOTE, note_latched, dur);
                next_state = ST_WR_ADV;
            end
            ST_WR_ADV: begin
                write = 1'b1;
                data  = make_entry(TYPE_ADVANCE, '0, dur);
                if (record) begin
                    next_state = ST_ARMED;
                end else begin
                    next_state  = ST_IDLE;
                    session_end = 1'b1;
                end
            end
            ST_FULL: begin
                if (!record) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        if (write && (entry_idx == '1)) begin
            next_state  = ST_FULL;
            session_end = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Input registers used for edge detection and note sampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            record_q <= 1'b0;
            key_q    <= 1'b0;
            note_q   <= '0;
        end else begin
            record_q <= record;
            key_q    <= key_pressed;
            note_q   <= key_note;
        end
    end

    // Session song slot and the note of the current press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            song_latched <= '0;
            note_latched <= '0;
        end else begin
            if (latch_song) song_latched <= song;
            if (latch_note) note_latched <= note_q;
        end
    end

    // Write index and per-session entry count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_idx   <= '0;
            entry_count <= '0;
        end else if (latch_song) begin
            entry_idx   <= '0;
            entry_count <= '0;
        end else if (write) begin
            entry_idx   <= entry_idx + 1'b1;
            entry_count <= entry_count + 1'b1;
        end
    end

    // One-cycle session-end pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) record_done <= 1'b0;
        else       record_done <= session_end;
    end

    assign ram.wr_en   = write;
    assign ram.wr_addr = {song_latched, entry_idx};
    assign ram.wr_data = data;
    assign recording   = (state != ST_IDLE) && (state != ST_FULL);
    assign full        = (state == ST_FULL);

endmodule

// File: doc/song_writer.md
Name: song_writer

Overview:
- Monophonic live recorder. Encodes key presses timed against a beat tick into 16-bit song entries and writes them into the song RAM.
- The written entries are the format song_reader plays back.
- Sits between the keyboard/beat-generator front end and the write port of the song RAM. song_reader owns the read port.

Parameters:
- SONG_WIDTH, 7, entry-index width (128 entries per song)
- NOTE_WIDTH, 6, note code width
- DURATION_WIDTH, 6, beat-count width; counts saturate at 63

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- record  in  1  level; high = recording session active
- song  in  2  target song slot; latched when a session starts
- beat_tick  in  1  one-cycle pulse per beat
- key_pressed  in  1  level; a key is held
- key_note  in  6  note code; sampled on the press edge
- wr_en  out  1  RAM write strobe
- wr_addr  out  9  {song_latched, entry_idx}
- wr_data  out  16  encoded entry
- recording  out  1  high while a session is active (not IDLE/FULL)
- full  out  1  high in FULL
- record_done  out  1  one-cycle pulse when a session ends (normal stop or full)
- entry_count  out  8  entries written this session, 0..128

Behaviour:
- Entry format:
  - [15] type: 0 = note, 1 = advance
  - [14:9] note code (0 for advance)
  - [8:3] duration in beats
  - [2:0] metadata, always 000
- Reset: state IDLE. entry_idx, entry_count, beat counter, latched note and latched song all 0. All outputs 0.
- Beat counter:
  - Cleared on entry to ARMED or HELD.
  - Increments on beat_tick while in ARMED or HELD; saturates at 63.
  - Value written as a duration is max(count, 1).
- States and transitions:
  - IDLE: on a record rising edge, latch song, clear entry_idx/entry_count, go to ARMED. record held high after FULL does not restart; a new rising edge is required.
  - ARMED (counting a gap):
    - record low -> IDLE with a record_done pulse; a trailing rest is not written.
    - key_pressed high -> latch key_note. If gap count > 0 go to WR_REST, otherwise go to HELD.
  - HELD (counting hold time): key_pressed low, or record low -> WR_NOTE.
  - WR_REST: one cycle, wr_en=1, writes advance entry with duration = gap. Then HELD; the counter restarts at 0.
  - WR_NOTE: one cycle, wr_en=1, writes note entry {0, note, dur, 000}. Then WR_ADV.
  - WR_ADV: one cycle, wr_en=1, writes advance entry with the same duration. Then ARMED if record is high, else IDLE with a record_done pulse.
  - FULL: full=1. Leave to IDLE when record is low.
- Every write increments entry_idx and entry_count in the same cycle. wr_addr uses the pre-increment index.
- Capacity:
  - A write at index 127 goes directly to FULL after that cycle and pulses record_done, overriding the normal next state.
  - A WR_NOTE at index 127 therefore drops its WR_ADV.
  - A WR_REST at index 127 leaves the note unwritten.
  - entry_count reads 128 in FULL.
- Timing:
  - Key edges are detected on registered key_pressed.
  - Key or beat events that arrive during a write cycle are honoured in the next counting state; a beat_tick coincident with a write cycle is dropped.
  - beat_tick and the key edge in the same cycle: the tick counts toward the state being left.
- Asynchronous reset mid-write aborts the write; wr_en drops immediately.

Decomposition:
- Shared package or include file, common with song_reader:
  - width defines: SONG_WIDTH, NOTE_WIDTH, DURATION_WIDTH, METADATA
  - entry field offsets
  - TYPE_NOTE / TYPE_ADVANCE codes
  - state encodings
- Sub-module beat_counter: 6-bit saturating counter with clear and tick enable.
- All registers are dffr instances (asynchronous active-high reset); next-state logic is combinational.

Test Plan:
- Immediate press then release: record rises; key 0x15 pressed at once, released after 3 ticks -> two writes: addr {song,0}=0x2A18, addr {song,1}=0x8018; then ARMED, entry_count=2.
- Rest before a note: 2 ticks idle, press 0x0A, 0 ticks, release -> 0x8010 (rest 2), 0x1408 (dur clamped to 1), 0x8008.
- Stop while held: record falls while key held after 5 ticks -> note dur 5, advance 5, record_done pulse, IDLE.
- Saturation: hold for 70 ticks -> duration field 63 in both entries.
- Overflow: 63 note pairs fill entries 0..125, a rest lands at 126, and the next note write lands at 127 -> full=1, record_done pulse, WR_ADV suppressed, entry_count=128. Releasing record returns to IDLE.
- Reset mid-session: assert reset during WR_NOTE -> wr_en=0 in the same cycle, all outputs 0. A new record edge restarts at addr {song,0}.
